// File: rtl/logic_pkg.sv
// Shared encodings for the Mini-MIPS logic unit: func codes, opcodes, functs.
// Pure definitions; no latency or flow-control behaviour.
package logic_pkg;

    localparam logic [2:0] LF_AND = 3'b000;
    localparam logic [2:0] LF_OR  = 3'b001;
    localparam logic [2:0] LF_XOR = 3'b010;
    localparam logic [2:0] LF_NOR = 3'b011;
    localparam logic [2:0] LF_NOT = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_NOT = 6'h28;

    typedef enum logic [1:0] {
        BSEL_RT   = 2'd0,
        BSEL_IMM  = 2'd1,
        BSEL_ZERO = 2'd2
    } bsel_t;

endpackage

// File: rtl/logic_issue_decode.sv
// Opcode/funct -> logic func code, b-operand select and illegal flag.
// Purely combinational; no flow control.
module logic_issue_decode
    import logic_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_func,
    output logic [1:0] o_bsel,
    output logic       o_illegal
);

    bsel_t w_bsel;

    always_comb begin
        o_func    = LF_AND;
        w_bsel    = BSEL_ZERO;
        o_illegal = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_illegal = 1'b0;
                w_bsel    = BSEL_RT;
                case (i_funct)
                    FN_AND:  o_func = LF_AND;
                    FN_OR:   o_func = LF_OR;
                    FN_XOR:  o_func = LF_XOR;
                    FN_NOR:  o_func = LF_NOR;
                    FN_NOT: begin
                        o_func = LF_NOT;
                        w_bsel = BSEL_ZERO;
                    end
                    default: begin
                        o_illegal = 1'b1;
                        w_bsel    = BSEL_ZERO;
                    end
                endcase
            end
            OP_ANDI: begin o_illegal = 1'b0; w_bsel = BSEL_IMM; o_func = LF_AND; end
            OP_ORI:  begin o_illegal = 1'b0; w_bsel = BSEL_IMM; o_func = LF_OR;  end
            OP_XORI: begin o_illegal = 1'b0; w_bsel = BSEL_IMM; o_func = LF_XOR; end
            default: ;
        endcase
        o_bsel = w_bsel;
    end

endmodule

// File: rtl/logic_issue_unit.sv
// Issues decoded operands to the logic unit and registers its result with rd tag.
// 2 edges accept->out_valid, full rate; output holds under !out_ready, flush drops both stages.
module logic_issue_unit
    import logic_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [DW-1:0]    in_rs_val,
    input  logic [DW-1:0]    in_rt_val,
    input  logic [15:0]      in_imm,
    input  logic [4:0]       in_rd,
    output logic [DW-1:0]    lu_a,
    output logic [DW-1:0]    lu_b,
    output logic [2:0]       lu_func,
    input  logic [DW-1:0]    lu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [4:0]       out_rd,
    output logic             out_err,
    output logic [CNT_W-1:0] ops_done,
    output logic [CNT_W-1:0] ops_illegal
);

    logic [2:0]    w_func;
    logic [1:0]    w_bsel;
    logic          w_illegal;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic          w_s2_free;
    logic          w_s1_adv;
    logic          w_accept;

    logic          r_s1_vld;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [2:0]    r_func;
    logic [4:0]    r_s1_rd;
    logic          r_s1_ill;

    logic          r_out_vld;
    logic [DW-1:0] r_out_dat;
    logic [4:0]    r_out_rd;
    logic          r_out_err;
    logic [CNT_W-1:0] r_done;
    logic [CNT_W-1:0] r_illegal;

    logic_issue_decode u_decode (
        .i_opcode  (in_opcode),
        .i_funct   (in_funct),
        .o_func    (w_func),
        .o_bsel    (w_bsel),
        .o_illegal (w_illegal)
    );

    // Illegal bundles present all-zero operands so the unit never sees garbage.
    always_comb begin
        w_a = w_illegal ? '0 : in_rs_val;
        case (bsel_t'(w_bsel))
            BSEL_RT:  w_b = in_rt_val;
            BSEL_IMM: w_b = {{(DW-16){1'b0}}, in_imm};
            default:  w_b = '0;
        endcase
    end

    assign w_s2_free = !r_out_vld || out_ready;
    assign w_s1_adv  = r_s1_vld && w_s2_free;
    assign in_ready  = !flush && (!r_s1_vld || w_s2_free);
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_func   <= LF_AND;
            r_s1_rd  <= '0;
            r_s1_ill <= 1'b0;
        end else if (flush) begin
            r_s1_vld <= 1'b0;
        end else if (w_accept) begin
            r_s1_vld <= 1'b1;
            r_a      <= w_a;
            r_b      <= w_b;
            r_func   <= w_illegal ? LF_AND : w_func;
            r_s1_rd  <= in_rd;
            r_s1_ill <= w_illegal;
        end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_rd  <= '0;
            r_out_err <= 1'b0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_vld <= 1'b1;
            r_out_dat <= r_s1_ill ? '0 : lu_out;
            r_out_rd  <= r_s1_rd;
            r_out_err <= r_s1_ill;
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    // Counters see the consumer handshake only; flush never rewinds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done    <= '0;
            r_illegal <= '0;
        end else if (r_out_vld && out_ready) begin
            r_done <= r_done + CNT_W'(1);
            if (r_out_err) begin
                r_illegal <= r_illegal + CNT_W'(1);
            end
        end
    end

    assign lu_a        = r_a;
    assign lu_b        = r_b;
    assign lu_func     = r_func;
    assign out_valid   = r_out_vld;
    assign out_data    = r_out_dat;
    assign out_rd      = r_out_rd;
    assign out_err     = r_out_err;
    assign ops_done    = r_done;
    assign ops_illegal = r_illegal;

endmodule

// File: tb/tb_logic_issue_unit.sv
// Directed bench for logic_issue_unit with a behavioural logic unit on lu_*.
module tb_logic_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [15:0] in_imm;
    logic [4:0]  in_rd;
    logic [31:0] lu_a;
    logic [31:0] lu_b;
    logic [2:0]  lu_func;
    logic [31:0] lu_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;
    logic [15:0] ops_done;
    logic [15:0] ops_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (lu_func)
            3'b000:  lu_out = lu_a & lu_b;
            3'b001:  lu_out = lu_a | lu_b;
            3'b010:  lu_out = lu_a ^ lu_b;
            3'b011:  lu_out = ~(lu_a | lu_b);
            3'b100:  lu_out = ~lu_a;
            default: lu_out = 32'h0;
        endcase
    end

    logic_issue_unit #(.DW(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct    (in_funct),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .in_imm      (in_imm),
        .in_rd       (in_rd),
        .lu_a        (lu_a),
        .lu_b        (lu_b),
        .lu_func     (lu_func),
        .lu_out      (lu_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_err     (out_err),
        .ops_done    (ops_done),
        .ops_illegal (ops_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input logic [4:0] rd);
        in_opcode = op;
        in_funct  = fn;
        in_rs_val = rs;
        in_rt_val = rt;
        in_imm    = imm;
        in_rd     = rd;
        in_valid  = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] exp_dat;
    logic        found;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct = '0; in_rs_val = '0; in_rt_val = '0; in_imm = '0; in_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_lu_a", lu_a, 0);
        chk("rst_lu_b", lu_b, 0);
        chk("rst_lu_func", lu_func, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_ops_illegal", ops_illegal, 0);
        chk("rst_in_ready", in_ready, 1);

        // R-type AND: latency and data
        @(negedge clk);
        out_ready = 1'b1;
        drive(6'h00, 6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'h0, 5'd5);
        tick();
        idle();
        chk("and_lu_func", lu_func, 3'b000);
        chk("and_lu_a", lu_a, 32'hF0F0_1234);
        chk("and_lu_b", lu_b, 32'h0FF0_FFFF);
        chk("and_not_yet_valid", out_valid, 0);
        tick();
        chk("and_valid", out_valid, 1);
        chk("and_data", out_data, 32'h00F0_1234);
        chk("and_rd", out_rd, 5);
        chk("and_err", out_err, 0);
        tick();
        chk("and_drained", out_valid, 0);
        chk("and_ops_done", ops_done, 1);

        // ori zero-extends the immediate
        drive(6'h0D, 6'h00, 32'h1234_0000, 32'hFFFF_FFFF, 16'h8001, 5'd7);
        tick();
        idle();
        chk("ori_lu_b", lu_b, 32'h0000_8001);
        chk("ori_lu_func", lu_func, 3'b001);
        tick();
        chk("ori_data", out_data, 32'h1234_8001);

        // NOT ignores rt
        drive(6'h00, 6'h28, 32'h0, 32'hDEAD_BEEF, 16'h0, 5'd9);
        tick();
        idle();
        chk("not_lu_b", lu_b, 0);
        chk("not_lu_func", lu_func, 3'b100);
        tick();
        chk("not_data", out_data, 32'hFFFF_FFFF);
        chk("not_rd", out_rd, 9);

        // Reset so the stream count starts from zero
        tick();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("rst2_ops_done", ops_done, 0);

        // 8 back-to-back xori ops, results on consecutive cycles
        @(negedge clk);
        for (int c = 0; c <= 10; c++) begin
            if (c >= 2 && c < 10) begin
                exp_dat = (c - 2) ^ (32'h00F0 + (c - 2));
                chk("stream_valid", out_valid, 1);
                chk("stream_data", out_data, exp_dat);
                chk("stream_rd", out_rd, 5'(c - 2));
            end
            if (c == 10) begin
                chk("stream_end_valid", out_valid, 0);
                chk("stream_ops_done", ops_done, 8);
            end
            if (c < 8) begin
                drive(6'h0E, 6'h00, 32'(c), 32'h0, 16'(16'h00F0 + c), 5'(c));
                #1;
                chk("stream_in_ready", in_ready, 1);
            end else begin
                idle();
            end
            tick();
        end

        // Backpressure: three ops offered, two accepted while blocked
        out_ready = 1'b0;
        drive(6'h00, 6'h25, 32'h0000_0100, 32'h1, 16'h0, 5'd11);
        tick();
        drive(6'h00, 6'h25, 32'h0000_0200, 32'h2, 16'h0, 5'd12);
        tick();
        drive(6'h00, 6'h25, 32'h0000_0300, 32'h3, 16'h0, 5'd13);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data_stable", out_data, 32'h0000_0101);
            chk("bp_rd_stable", out_rd, 11);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        idle();
        chk("bp_drain_b", out_data, 32'h0000_0202);
        chk("bp_drain_b_rd", out_rd, 12);
        tick();
        chk("bp_drain_c", out_data, 32'h0000_0303);
        chk("bp_drain_c_rd", out_rd, 13);
        tick();
        chk("bp_no_dup", out_valid, 0);
        chk("bp_ops_done", ops_done, 11);

        // Illegal opcode
        drive(6'h23, 6'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 5'd3);
        tick();
        idle();
        chk("ill_lu_a", lu_a, 0);
        chk("ill_lu_b", lu_b, 0);
        chk("ill_lu_func", lu_func, 0);
        tick();
        chk("ill_valid", out_valid, 1);
        chk("ill_err", out_err, 1);
        chk("ill_data", out_data, 0);
        tick();
        chk("ill_count", ops_illegal, 1);
        chk("ill_ops_done", ops_done, 12);

        // Run the completion counter up to its wrap point
        drive(6'h00, 6'h25, 32'h1, 32'h2, 16'h0, 5'd1);
        found = 1'b0;
        for (int c = 0; c < 70000 && !found; c++) begin
            tick();
            if (ops_done == 16'hFFFF) found = 1'b1;
        end
        chk("wrap_reached", found, 1);
        tick();
        chk("wrap_zero", ops_done, 0);
        chk("wrap_illegal_kept", ops_illegal, 1);
        idle();
        repeat (3) tick();

        // Flush with both stages full
        out_ready = 1'b0;
        drive(6'h0C, 6'h00, 32'hFFFF_FFFF, 32'h0, 16'h00FF, 5'd1);
        tick();
        drive(6'h0E, 6'h00, 32'h0, 32'h0, 16'h0001, 5'd2);
        tick();
        chk("flush_pre_valid", out_valid, 1);
        flush = 1'b1;
        drive(6'h0D, 6'h00, 32'h0, 32'h0, 16'h0003, 5'd3);
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_valid_cleared", out_valid, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("flush_no_stale", out_valid, 0);
        end
        drive(6'h0C, 6'h00, 32'hABCD_1234, 32'h0, 16'hFF00, 5'd4);
        tick();
        idle();
        tick();
        chk("flush_after_valid", out_valid, 1);
        chk("flush_after_data", out_data, 32'h0000_1200);
        chk("flush_after_rd", out_rd, 4);
        tick();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(6'h0D, 6'h00, 32'h0, 32'h0, 16'h0005, 5'd6);
        tick();
        drive(6'h0D, 6'h00, 32'h0, 32'h0, 16'h0006, 5'd7);
        tick();
        idle();
        chk("rstmid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_data", out_data, 0);
        chk("rstmid_lu_a", lu_a, 0);
        chk("rstmid_lu_b", lu_b, 0);
        chk("rstmid_ops_done", ops_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rstmid_no_stale", out_valid, 0);
        end
        drive(6'h00, 6'h27, 32'h0F0F_0F0F, 32'hF0F0_0000, 16'h0, 5'd8);
        tick();
        idle();
        chk("nor_lu_func", lu_func, 3'b011);
        tick();
        chk("nor_valid", out_valid, 1);
        chk("nor_data", out_data, 32'h0000_F0F0);
        chk("nor_rd", out_rd, 8);
        tick();
        chk("nor_ops_done", ops_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_issue_unit.md
Name: logic_issue_unit

Overview:
- Initiator side of the logic-unit func/operand interface. Accepts decoded-instruction operand bundles through a valid/ready handshake.
- Maps MIPS opcode/funct to the 3-bit logic func code and drives a, b and func to the combinational logic unit. Registers the returned result and presents it with destination tag through an output valid/ready handshake.
- Sits between the register-read stage and writeback in the Mini-MIPS execute path.
- 2-stage pipeline, full throughput, backpressure-safe.

Parameters:
- DW, 32, operand/result width
- CNT_W, 16, width of completed-op and illegal-op counters

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; kills both stages
- in_valid  input  1  operand bundle valid
- in_ready  output  1  bundle accepted when in_valid && in_ready
- in_opcode  input  6  instruction opcode
- in_funct  input  6  R-type funct
- in_rs_val  input  DW  rs operand
- in_rt_val  input  DW  rt operand
- in_imm  input  16  I-type immediate
- in_rd  input  5  destination register tag
- lu_a  output  DW  operand a to logic unit
- lu_b  output  DW  operand b to logic unit
- lu_func  output  3  func to logic unit
- lu_out  input  DW  combinational result from logic unit
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_data  output  DW  result
- out_rd  output  5  destination tag
- out_err  output  1  op was illegal
- ops_done  output  CNT_W  completed-op count
- ops_illegal  output  CNT_W  illegal-op count

Behaviour:
- Decode table, opcode 0x00:
  - funct 0x24 → AND 000, b=rt
  - funct 0x25 → OR 001, b=rt
  - funct 0x26 → XOR 010, b=rt
  - funct 0x27 → NOR 011, b=rt
  - funct 0x28 → NOT 100 (team extension), b=0
- Decode table, I-type (b = imm zero-extended to DW):
  - opcode 0x0C andi → 000
  - opcode 0x0D ori → 001
  - opcode 0x0E xori → 010
- a = rs in all cases.
- Any other opcode/funct is illegal:
  - Bundle still flows through the pipeline.
  - lu_func=000, lu_a=lu_b=0.
  - Stage 2 forces out_data=0 and out_err=1.
- Stage 1 (issue register):
  - Captures decoded a, b, func, rd and illegal flag on accept.
  - lu_a, lu_b and lu_func are driven directly from stage-1 registers (glitch-free to the unit).
- Stage 2 (result register):
  - Captures lu_out, rd and err when stage 1 advances.
- Handshake:
  - s2_free = !out_valid || out_ready
  - s1_adv = s1_valid && s2_free
  - in_ready = !s1_valid || s2_free
  - Combinational; in_ready never depends on in_valid.
- Latency: accept at edge N → out_valid high after edge N+1 with correct data.
- Throughput: one op per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_data, out_rd and out_err hold stable. Stage 1 holds; in_ready drops once stage 1 is occupied.
- Simultaneous accept-in and drain-out in the same cycle: both occur, no bubble, no loss.
- Counters:
  - ops_done increments on each out_valid && out_ready; ops_illegal increments when that handshake also has out_err=1.
  - Both wrap from 2^CNT_W−1 to 0. Counters are not cleared by flush.
- flush:
  - Next edge clears s1_valid and out_valid; an in_valid in the flush cycle is dropped.
  - in_ready is forced 0 during flush.
  - Data registers need not clear.
- Reset values: out_valid=0, out_data=0, out_rd=0, out_err=0, lu_a=0, lu_b=0, lu_func=000, ops_done=0, ops_illegal=0. in_ready=1 after reset.
- Reset asserted mid-operation: in-flight ops are discarded immediately and asynchronously; outputs return to reset values.

Decomposition:
- Shared package logic_pkg:
  - func codes LF_AND=000, LF_OR=001, LF_XOR=010, LF_NOR=011, LF_NOT=100
  - opcode constants OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI
  - funct constants FN_AND, FN_OR, FN_XOR, FN_NOR, FN_NOT
- One natural sub-module: logic_issue_decode (combinational opcode/funct/imm → func, b-select, illegal), reusable by the ALU control path.

Test Plan:
- R-type AND, rs=0xF0F0_1234, rt=0x0FF0_FFFF, rd=5, out_ready=1 → lu_func=000 one cycle after accept; out_data=0x00F0_1234, out_rd=5, out_err=0; out_valid exactly 2 edges after accept.
- ori rs=0x1234_0000, imm=0x8001 → b=0x0000_8001 (zero-extend, not sign), out_data=0x1234_8001. NOT rs=0 → out_data=0xFFFF_FFFF.
- Back-to-back stream of 8 ops with out_ready=1 → 8 results on consecutive cycles, in order; ops_done=8.
- Backpressure: out_ready=0 for 5 cycles with 3 ops offered → only 2 accepted, in_ready=0; out_data stable; on release, all 3 drain in order, no duplication.
- Illegal opcode 0x23 → out_err=1, out_data=0, ops_illegal=1. Preload near wrap: ops_done wraps 0xFFFF→0x0000.
- flush with both stages full, and separately rst_n low mid-stream → out_valid=0 next edge (reset: immediately); no stale results appear afterward; subsequent op completes normally.
